// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: operand/operator collection FSM in front of the
// combinational calculator ALU. It collects K, the operator and M, holds them
// for SETTLE_CYCLES, then captures the ALU result and overflow flag.
// Optional macro CALC_CHAIN_EN: an operator pulse in S_DONE reuses
// result[7:0] as the next K.
module calc_op_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  sw,
  input  logic        enter,
  input  logic        op_add,
  input  logic        op_sub,
  input  logic        op_mul,
  input  logic        op_div,
  input  logic        op_exp,
  input  logic [15:0] alu_r,
  input  logic        alu_ovf,
  output logic [7:0]  K,
  output logic [7:0]  M,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        EXP,
  output logic [15:0] result,
  output logic        ovf,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_K    = 3'd0,
    S_OP   = 3'd1,
    S_M    = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     st, st_nx;
  logic [4:0] ops, op_q;
  logic [7:0] cnt;
  logic       op_one;
  logic       ld_k_sw, ld_k_res, ld_op, ld_m, cap, dec;

  assign ops    = {op_exp, op_div, op_mul, op_sub, op_add};
  // Exactly one operator request; zero or several are treated as no request.
  assign op_one = (ops != 5'd0) && ((ops & (ops - 5'd1)) == 5'd0);

  // Next-state and datapath load enables; clr overrides everything.
  always_comb begin
    st_nx    = st;
    ld_k_sw  = 1'b0;
    ld_k_res = 1'b0;
    ld_op    = 1'b0;
    ld_m     = 1'b0;
    cap      = 1'b0;
    dec      = 1'b0;
    if (clr) begin
      st_nx = S_K;
    end else begin
      case (st)
        S_K:    if (enter) begin ld_k_sw = 1'b1; st_nx = S_OP; end
        S_OP:   if (op_one) begin ld_op = 1'b1; st_nx = S_M; end
        S_M:    if (enter) begin ld_m = 1'b1; st_nx = S_EXEC; end
        S_EXEC: begin
          if (cnt == 8'd0) begin
            cap   = 1'b1;
            st_nx = S_DONE;
          end else begin
            dec = 1'b1;
          end
        end
        S_DONE: begin
          if (enter) begin
            ld_k_sw = 1'b1;
            st_nx   = S_OP;
          end
`ifdef CALC_CHAIN_EN
          else if (op_one) begin
            // Previous answer's low byte becomes the next K.
            ld_k_res = 1'b1;
            ld_op    = 1'b1;
            st_nx    = S_M;
          end
`endif
        end
        default: st_nx = S_K;
      endcase
    end
  end

  // Operator lines are only driven while the ALU is settling.
  always_comb begin
    {EXP, DIV, MUL, SUB, ADD} = (st == S_EXEC) ? op_q : 5'd0;
    busy  = (st == S_EXEC);
    state = st;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_K;
    else     st <= st_nx;
  end

  // Operand, operator, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      K <= '0; M <= '0; op_q <= '0; cnt <= '0;
      result <= '0; ovf <= 1'b0; done <= 1'b0;
    end else if (clr) begin
      K <= '0; M <= '0; op_q <= '0; cnt <= '0;
      result <= '0; ovf <= 1'b0; done <= 1'b0;
    end else begin
      done <= cap;
      if (ld_k_sw)  K <= sw;
      if (ld_k_res) K <= result[7:0];
      if (ld_op)    op_q <= ops;
      if (ld_m) begin
        M   <= sw;
        cnt <= 8'(SETTLE_CYCLES - 1);
      end
      if (dec) cnt <= cnt - 8'd1;
      if (cap) begin
        result <= alu_r;
        ovf    <= alu_ovf;
      end
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Testbench for calc_op_sequencer: directed scenarios plus randomized
// transactions against a transaction-level model with a behavioural ALU.
module tb_calc_op_sequencer;
  localparam int SETTLE = 4;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, enter = 1'b0, alu_ovf;
  logic [7:0] sw = '0;
  logic [4:0] opv = '0;
  logic [15:0] alu_r, noise = '0;
  logic noise_mode = 1'b0;
  logic [7:0] K, M;
  logic ADD, SUB, MUL, DIV, EXP, ovf, busy, done;
  logic [15:0] result;
  logic [2:0] state;
  wire [4:0] oline = {EXP, DIV, MUL, SUB, ADD};
  int checks = 0, errors = 0;

  calc_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .clr(clr), .sw(sw), .enter(enter),
    .op_add(opv[0]), .op_sub(opv[1]), .op_mul(opv[2]), .op_div(opv[3]), .op_exp(opv[4]),
    .alu_r(alu_r), .alu_ovf(alu_ovf), .K(K), .M(M),
    .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .EXP(EXP),
    .result(result), .ovf(ovf), .busy(busy), .done(done), .state(state));

  always #5 clk = ~clk;

  // Behavioural 8-bit signed ALU: {ovf, r[15:0]}.
  function automatic logic [16:0] alu_f(input logic [7:0] k, input logic [7:0] m, input logic [4:0] o);
    int a, b, r;
    logic v;
    a = int'($signed(k)); b = int'($signed(m)); r = 0; v = 1'b0;
    case (o)
      5'b00001: begin r = a + b; v = (r > 127) || (r < -128); end
      5'b00010: begin r = a - b; v = (r > 127) || (r < -128); end
      5'b00100: r = a * b;
      5'b01000: if (b == 0) v = 1'b1; else r = (((a / b) & 255) << 8) | ((a % b) & 255);
      5'b10000: r = a << (b & 3);
      default:  r = 0;
    endcase
    return {v, r[15:0]};
  endfunction

  always_comb begin
    if (noise_mode) {alu_ovf, alu_r} = {noise[0] ^ noise[15], noise};
    else            {alu_ovf, alu_r} = alu_f(K, M, oline);
  end

  // One clock cycle with the given pulse inputs; outputs settle 1ns after the edge.
  task automatic cyc(input logic e, input logic [4:0] o, input logic [7:0] s, input logic c);
    sw = s; enter = e; opv = o; clr = c;
    @(posedge clk); #1;
    enter = 1'b0; opv = '0; clr = 1'b0;
    noise = 16'($urandom);
  endtask

  // Called right after the M-enter edge; walks the settle window and capture.
  task automatic run_exec(input logic [7:0] ke, input logic [7:0] me, input logic [4:0] oe, input bit junk);
    logic [16:0] exp_v;
    exp_v = '0;
    for (int c = 0; c < SETTLE; c++) begin
      checks++;
      if (state !== 3'd3 || busy !== 1'b1 || oline !== oe || done !== 1'b0) begin
        errors++;
        $display("FAIL exec_cyc%0d: state=%0d busy=%b ops=%b done=%b, want state=3 busy=1 ops=%b done=0", c, state, busy, oline, done, oe);
      end
      checks++;
      if (K !== ke || M !== me) begin
        errors++;
        $display("FAIL exec_hold%0d: K=%h M=%h, want K=%h M=%h", c, K, M, ke, me);
      end
      if (c == SETTLE - 1) exp_v = noise_mode ? {noise[0] ^ noise[15], noise} : alu_f(ke, me, oe);
      if (junk) cyc($urandom_range(0, 1), 5'(1 << $urandom_range(0, 4)), 8'($urandom), 1'b0);
      else      cyc(1'b0, 5'd0, 8'h00, 1'b0);
    end
    checks++;
    if (state !== 3'd4 || busy !== 1'b0 || done !== 1'b1 || oline !== 5'd0) begin
      errors++;
      $display("FAIL capture: state=%0d busy=%b done=%b ops=%b, want 4 0 1 00000", state, busy, done, oline);
    end
    checks++;
    if ({ovf, result} !== exp_v) begin
      errors++;
      $display("FAIL result: got ovf=%b r=%h, want ovf=%b r=%h", ovf, result, exp_v[16], exp_v[15:0]);
    end
    cyc(1'b0, 5'd0, 8'h00, 1'b0);
    checks++;
    if (done !== 1'b0 || state !== 3'd4 || {ovf, result} !== exp_v) begin
      errors++;
      $display("FAIL done_pulse: done=%b state=%0d r=%h, want 0 4 %h", done, state, result, exp_v[15:0]);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (K !== 0 || M !== 0 || oline !== 0 || result !== 0 || ovf !== 0 || busy !== 0 || done !== 0 || state !== 0) begin
      errors++;
      $display("FAIL reset: K=%h M=%h ops=%b r=%h ovf=%b busy=%b done=%b state=%0d, want all 0", K, M, oline, result, ovf, busy, done, state);
    end
  endtask

  task automatic test_add;
    noise_mode = 1'b0;
    cyc(1'b1, 5'd0, 8'd5, 1'b0);
    checks++;
    if (state !== 3'd1 || K !== 8'd5) begin errors++; $display("FAIL add_k: state=%0d K=%h, want 1 05", state, K); end
    cyc(1'b0, 5'b00001, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL add_op: state=%0d, want 2", state); end
    cyc(1'b1, 5'd0, 8'hFD, 1'b0);
    run_exec(8'd5, 8'hFD, 5'b00001, 1'b0);
    checks++;
    if (result !== 16'd2 || ovf !== 1'b0) begin errors++; $display("FAIL add_value: r=%h ovf=%b, want 0002 0", result, ovf); end
  endtask

  task automatic test_simul_ops;
    noise_mode = 1'b0;
    cyc(1'b1, 5'd0, 8'd100, 1'b0);
    cyc(1'b0, 5'b01100, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL simul_ops: state=%0d, want 1", state); end
    cyc(1'b1, 5'd0, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd1 || K !== 8'd100) begin errors++; $display("FAIL op_enter: state=%0d K=%h, want 1 64", state, K); end
    cyc(1'b0, 5'b01000, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL div_alone: state=%0d, want 2", state); end
    cyc(1'b0, 5'b00100, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL m_op_ignore: state=%0d, want 2", state); end
    cyc(1'b1, 5'd0, 8'd7, 1'b0);
    run_exec(8'd100, 8'd7, 5'b01000, 1'b0);
    checks++;
    if (result !== 16'h0E02) begin errors++; $display("FAIL div_value: r=%h, want 0e02", result); end
  endtask

  task automatic test_chain;
    noise_mode = 1'b0;
    cyc(1'b1, 5'd0, 8'd10, 1'b0);
    cyc(1'b0, 5'b00001, 8'h00, 1'b0);
    cyc(1'b1, 5'd0, 8'd10, 1'b0);
    run_exec(8'd10, 8'd10, 5'b00001, 1'b0);
    cyc(1'b0, 5'b00100, 8'h00, 1'b0);
`ifdef CALC_CHAIN_EN
    checks++;
    if (state !== 3'd2 || K !== 8'h14) begin errors++; $display("FAIL chain: state=%0d K=%h, want 2 14", state, K); end
    cyc(1'b1, 5'd0, 8'd3, 1'b0);
    run_exec(8'h14, 8'd3, 5'b00100, 1'b0);
    checks++;
    if (result !== 16'd60) begin errors++; $display("FAIL chain_value: r=%h, want 003c", result); end
`else
    checks++;
    if (state !== 3'd4 || K !== 8'd10 || result !== 16'h0014) begin
      errors++; $display("FAIL no_chain: state=%0d K=%h r=%h, want 4 0a 0014", state, K, result);
    end
`endif
  endtask

  // Random transactions with junk pulses in S_OP, S_M and S_EXEC; ALU bus is noise.
  task automatic test_random;
    logic [7:0] ke, me;
    logic [4:0] oe;
    int i, j;
    noise_mode = 1'b1;
    for (int n = 0; n < 25; n++) begin
      ke = 8'($urandom); me = 8'($urandom);
      oe = 5'(1 << $urandom_range(0, 4));
      cyc(1'b1, 5'd0, ke, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        i = $urandom_range(0, 4);
        j = (i + 1 + $urandom_range(0, 3)) % 5;
        cyc(1'b1, 5'((1 << i) | (1 << j)), 8'($urandom), 1'b0);
      end
      checks++;
      if (state !== 3'd1 || K !== ke) begin errors++; $display("FAIL rnd_k%0d: state=%0d K=%h, want 1 %h", n, state, K, ke); end
      cyc(1'b0, oe, 8'h00, 1'b0);
      if ($urandom_range(0, 1) == 1) cyc(1'b0, 5'(1 << $urandom_range(0, 4)), 8'h00, 1'b0);
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL rnd_m%0d: state=%0d, want 2", n, state); end
      cyc(1'b1, 5'd0, me, 1'b0);
      run_exec(ke, me, oe, 1'b1);
    end
  endtask

  task automatic test_async_reset;
    noise_mode = 1'b1;
    cyc(1'b1, 5'd0, 8'h33, 1'b0);
    cyc(1'b0, 5'b00010, 8'h00, 1'b0);
    cyc(1'b1, 5'd0, 8'h44, 1'b0);
    cyc(1'b0, 5'd0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset: state=%0d busy=%b, want 0 0", state, busy); end
  endtask

  task automatic test_abort;
    noise_mode = 1'b1;
    cyc(1'b1, 5'd0, 8'h21, 1'b0);
    cyc(1'b0, 5'b10000, 8'h00, 1'b0);
    cyc(1'b1, 5'd0, 8'h02, 1'b0);
    run_exec(8'h21, 8'h02, 5'b10000, 1'b0);
    cyc(1'b1, 5'd0, 8'h11, 1'b0);
    cyc(1'b0, 5'b00001, 8'h00, 1'b0);
    cyc(1'b1, 5'd0, 8'h22, 1'b0);
    cyc(1'b0, 5'd0, 8'h00, 1'b0);
    cyc(1'b0, 5'd0, 8'h00, 1'b1);
    test_reset;
    for (int c = 0; c < SETTLE + 2; c++) begin
      cyc(1'b0, 5'd0, 8'h00, 1'b0);
      checks++;
      if (done !== 1'b0 || state !== 3'd0 || result !== 16'd0) begin
        errors++; $display("FAIL abort%0d: done=%b state=%0d r=%h, want 0 0 0000", c, done, state, result);
      end
    end
  endtask

  initial begin
    #12 rst = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_add;
    test_simul_ops;
    test_chain;
    test_random;
    test_async_reset;
    test_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
